// File: rtl/uart_listener_pkg.sv
// Shared types and helpers for the UART listener: FSM state enums and baud divisor.
package uart_listener_pkg;

  localparam int unsigned DATA_BITS  = 8;
  localparam int unsigned FRAME_BITS = 10;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

  typedef enum logic [0:0] {
    TX_IDLE,
    TX_BUSY
  } tx_state_t;

  function automatic int unsigned baud_div(input int unsigned clk_hz, input int unsigned baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/uart_listener_if.sv
// Serial line and debug strobes of the UART listener; master is the listener side.
interface uart_listener_if;
  import uart_listener_pkg::*;

  logic                 rx;
  logic                 tx;
  logic [DATA_BITS-1:0] data;
  logic                 valid;
  logic                 ferr;
  logic                 ovr;

  modport master (input rx, output tx, data, valid, ferr, ovr);
  modport slave  (output rx, input tx, data, valid, ferr, ovr);

endinterface

// File: rtl/uart_listener_tx.sv
// 8N1 transmitter for the echo path: one baud counter, 10-bit frame shifter, drop strobe.
module uart_listener_tx
  import uart_listener_pkg::*;
#(
  parameter int unsigned DIV = 104
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [DATA_BITS-1:0] data,
  output logic                 tx,
  output logic                 ovr
);

  localparam int unsigned CNT_W = $clog2(DIV);

  tx_state_t        state;
  logic [CNT_W-1:0] cnt;
  logic [3:0]       bit_idx;
  logic [9:0]       shifter;
  logic             last_c;
  logic             ready_c;

  // The final cycle of the stop bit counts as free so a back-to-back byte is not dropped.
  assign last_c  = (state == TX_BUSY) && (cnt == CNT_W'(DIV - 1)) &&
                   (bit_idx == 4'(FRAME_BITS - 1));
  assign ready_c = (state == TX_IDLE) || last_c;

  // tx always mirrors shifter[0]; the shifter refills with idle ones from the top.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= TX_IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shifter <= '1;
      tx      <= 1'b1;
      ovr     <= 1'b0;
    end else begin
      ovr <= start && !ready_c;
      if (start && ready_c) begin
        state   <= TX_BUSY;
        cnt     <= '0;
        bit_idx <= '0;
        shifter <= {1'b1, data, 1'b0};
        tx      <= 1'b0;
      end else if (state == TX_BUSY) begin
        if (cnt == CNT_W'(DIV - 1)) begin
          cnt <= '0;
          if (bit_idx == 4'(FRAME_BITS - 1)) begin
            state <= TX_IDLE;
            tx    <= 1'b1;
          end else begin
            bit_idx <= bit_idx + 4'd1;
            shifter <= {1'b1, shifter[9:1]};
            tx      <= shifter[1];
          end
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/uart_listener.sv
// Simulation-side UART peer: decodes 8N1 frames from the SoC, strobes each byte,
// optionally echoes it back and prints it to the console.
module uart_listener
  import uart_listener_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ = 12_000_000,
  parameter int unsigned BAUD        = 115200,
  parameter bit          ECHO        = 1'b1,
  parameter bit          PRINT       = 1'b1
) (
  input logic            clk,
  input logic            rst_n,
  uart_listener_if.master bus
);

  localparam int unsigned DIV   = baud_div(CLK_FREQ_HZ, BAUD);
  localparam int unsigned HALF  = DIV / 2;
  localparam int unsigned CNT_W = $clog2(DIV);

  if (DIV < 4) begin : g_bad_div
    $fatal(1, "uart_listener: baud divisor %0d is below 4", DIV);
  end

  logic [1:0]           sync;
  logic                 rx_q;
  rx_state_t            state;
  logic [CNT_W-1:0]     cnt;
  logic [2:0]           bit_idx;
  logic [DATA_BITS-1:0] shreg;
  logic                 wait_high;
  logic [DATA_BITS-1:0] data;
  logic                 valid;
  logic                 ferr;
  logic                 tx;
  logic                 ovr;

  // Receive path: sync[1] is the synchronized line, rx_q its previous value for edge detect.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync      <= 2'b11;
      rx_q      <= 1'b1;
      state     <= RX_IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      wait_high <= 1'b0;
      data      <= '0;
      valid     <= 1'b0;
      ferr      <= 1'b0;
    end else begin
      sync  <= {sync[0], bus.rx};
      rx_q  <= sync[1];
      valid <= 1'b0;
      ferr  <= 1'b0;
      case (state)
        RX_IDLE: begin
          if (rx_q && !sync[1]) begin
            cnt   <= '0;
            state <= RX_START;
          end
        end
        RX_START: begin
          if (cnt == CNT_W'(HALF - 1)) begin
            cnt     <= '0;
            bit_idx <= '0;
            state   <= sync[1] ? RX_IDLE : RX_DATA;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        RX_DATA: begin
          if (cnt == CNT_W'(DIV - 1)) begin
            cnt     <= '0;
            shreg   <= {sync[1], shreg[DATA_BITS-1:1]};
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'(DATA_BITS - 1)) state <= RX_STOP;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        RX_STOP: begin
          // After a framing error, hold here until the line idles so a break is not a start.
          if (wait_high) begin
            if (sync[1]) begin
              wait_high <= 1'b0;
              state     <= RX_IDLE;
            end
          end else if (cnt == CNT_W'(DIV - 1)) begin
            cnt <= '0;
            if (sync[1]) begin
              data  <= shreg;
              valid <= 1'b1;
              state <= RX_IDLE;
            end else begin
              ferr      <= 1'b1;
              wait_high <= 1'b1;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: state <= RX_IDLE;
      endcase
    end
  end

  uart_listener_tx #(.DIV(DIV)) u_tx (
    .clk   (clk),
    .rst_n (rst_n),
    .start (valid && ECHO),
    .data  (data),
    .tx    (tx),
    .ovr   (ovr)
  );

  assign bus.tx    = tx;
  assign bus.data  = data;
  assign bus.valid = valid;
  assign bus.ferr  = ferr;
  assign bus.ovr   = ovr;

`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (PRINT && rst_n && valid) $write("%c", data);
  end
`endif

endmodule

// File: tb/tb_uart_listener.sv
// Bench for uart_listener: drives 8N1 frames and checks decoded bytes, echoes and strobes
// against byte lists predicted from the frames the bench sends.
module tb_uart_listener;

  localparam int unsigned CLK_HZ = 12_000_000;
  localparam int unsigned BAUD   = 115200;
  localparam int unsigned DIV    = CLK_HZ / BAUD;
  // Cycles from the first clock edge seeing the start bit to VALID: 9.5 bits + 2 sync.
  localparam int unsigned LAT    = (DIV * 19) / 2 + 2;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  int unsigned cyc   = 0;
  int          checks = 0;
  int          errors = 0;

  uart_listener_if bus ();

  uart_listener #(
    .CLK_FREQ_HZ (CLK_HZ),
    .BAUD        (BAUD),
    .ECHO        (1'b1),
    .PRINT       (1'b0)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  logic [7:0]  rx_got[$];
  logic [7:0]  echo_got[$];
  int unsigned echo_cyc[$];
  logic [7:0]  rx_exp[$];
  logic [7:0]  echo_exp[$];
  int          ferr_n = 0;
  int          ovr_n  = 0;
  int unsigned last_valid_cyc = 0;

  // Strobe monitor.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.valid === 1'b1) begin
        rx_got.push_back(bus.data);
        last_valid_cyc = cyc;
      end
      if (bus.ferr === 1'b1) ferr_n++;
      if (bus.ovr === 1'b1) ovr_n++;
    end
  end

  // Echo line decoder: mid-bit sampling at the nominal rate; a reset discards the frame.
  initial begin : echo_mon
    forever begin
      @(negedge clk);
      if (rst_n && bus.tx === 1'b0) begin
        logic [7:0]  b;
        bit          abort;
        int unsigned t0;
        b     = '0;
        abort = 1'b0;
        t0    = cyc;
        for (int k = 0; k < 10 && !abort; k++) begin
          int lim;
          lim = (k == 0) ? int'(DIV / 2) : int'(DIV);
          for (int n = 0; n < lim && !abort; n++) begin
            @(negedge clk);
            if (!rst_n) abort = 1'b1;
          end
          if (!abort) begin
            if (k == 0) check_eq("echo_start_bit", 32'(bus.tx), 32'd0);
            else if (k == 9) check_eq("echo_stop_bit", 32'(bus.tx), 32'd1);
            else b[k-1] = bus.tx;
          end
        end
        if (!abort) begin
          echo_got.push_back(b);
          echo_cyc.push_back(t0);
        end
      end
    end
  end

  initial begin : watchdog
    #800_000;
    $display("FAIL watchdog: simulation exceeded its cycle budget");
    $fatal(1, "watchdog expired");
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive_bit(input logic v, input int n);
    bus.rx = v;
    tick(n);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop, input int stop_len);
    drive_bit(1'b0, DIV);
    for (int i = 0; i < 8; i++) drive_bit(b[i], DIV);
    drive_bit(stop, stop_len);
  endtask

  int rx_base, echo_base, ferr_base, ovr_base;

  task automatic begin_scn();
    rx_base   = rx_got.size();
    echo_base = echo_got.size();
    ferr_base = ferr_n;
    ovr_base  = ovr_n;
    rx_exp.delete();
    echo_exp.delete();
  endtask

  task automatic end_scn(input string tag, input int ferr_e, input int ovr_e);
    tick(12 * DIV);
    check_eq({tag, "_rx_count"}, 32'(rx_got.size() - rx_base), 32'(rx_exp.size()));
    foreach (rx_exp[i])
      if (rx_base + i < rx_got.size())
        check_eq({tag, "_rx_byte"}, 32'(rx_got[rx_base + i]), 32'(rx_exp[i]));
    check_eq({tag, "_echo_count"}, 32'(echo_got.size() - echo_base), 32'(echo_exp.size()));
    foreach (echo_exp[i])
      if (echo_base + i < echo_got.size())
        check_eq({tag, "_echo_byte"}, 32'(echo_got[echo_base + i]), 32'(echo_exp[i]));
    check_eq({tag, "_ferr_count"}, 32'(ferr_n - ferr_base), 32'(ferr_e));
    check_eq({tag, "_ovr_count"}, 32'(ovr_n - ovr_base), 32'(ovr_e));
  endtask

  initial begin : stim
    int unsigned t_start;
    int unsigned echo_gap;
    logic [7:0]  b;
    int          nferr;

    bus.rx = 1'b1;
    rst_n  = 1'b0;
    tick(5);
    check_eq("reset_tx", 32'(bus.tx), 32'd1);
    check_eq("reset_data", 32'(bus.data), 32'd0);
    check_eq("reset_valid", 32'(bus.valid), 32'd0);
    check_eq("reset_ferr", 32'(bus.ferr), 32'd0);
    check_eq("reset_ovr", 32'(bus.ovr), 32'd0);
    rst_n = 1'b1;
    tick(DIV);

    // Single frame: decode, latency, echo one cycle after VALID.
    begin_scn();
    rx_exp.push_back(8'h41);
    echo_exp.push_back(8'h41);
    t_start = cyc;
    send_frame(8'h41, 1'b1, DIV);
    end_scn("frame41", 0, 0);
    check_eq("valid_latency", 32'(last_valid_cyc - t_start - 1), 32'(LAT));
    echo_gap = (echo_cyc.size() > 0) ? echo_cyc[echo_cyc.size() - 1] - last_valid_cyc : 0;
    check_eq("echo_next_cycle", 32'(echo_gap), 32'd1);
    check_eq("data_hold_41", 32'(bus.data), 32'h41);

    // Short low glitch is ignored; the following frame still decodes.
    begin_scn();
    drive_bit(1'b0, 3);
    drive_bit(1'b1, DIV);
    rx_exp.push_back(8'h7E);
    echo_exp.push_back(8'h7E);
    send_frame(8'h7E, 1'b1, DIV);
    end_scn("glitch", 0, 0);

    // Stop bit low: framing error, no byte, no echo.
    begin_scn();
    send_frame(8'h55, 1'b0, DIV);
    drive_bit(1'b1, DIV);
    end_scn("ferr55", 1, 0);
    check_eq("data_after_ferr", 32'(bus.data), 32'h7E);

    // Back-to-back frames with zero idle are both echoed.
    begin_scn();
    rx_exp.push_back(8'h48);
    rx_exp.push_back(8'h69);
    echo_exp.push_back(8'h48);
    echo_exp.push_back(8'h69);
    send_frame(8'h48, 1'b1, DIV);
    send_frame(8'h69, 1'b1, DIV);
    end_scn("b2b", 0, 0);

    // Shortened stop bit makes the second byte arrive while the echo is busy.
    begin_scn();
    rx_exp.push_back(8'h31);
    rx_exp.push_back(8'h32);
    echo_exp.push_back(8'h31);
    send_frame(8'h31, 1'b1, DIV / 2 + 8);
    send_frame(8'h32, 1'b1, DIV);
    end_scn("overrun", 0, 1);

    // Reset in the middle of the next frame's data, while the echo of 0xC3 is on bit d3 (0).
    begin_scn();
    rx_exp.push_back(8'hC3);
    send_frame(8'hC3, 1'b1, DIV);
    drive_bit(1'b0, 4 * DIV);
    check_eq("data_before_reset", 32'(bus.data), 32'hC3);
    check_eq("tx_mid_echo", 32'(bus.tx), 32'd0);
    rst_n = 1'b0;
    #1;
    check_eq("rst_tx", 32'(bus.tx), 32'd1);
    check_eq("rst_data", 32'(bus.data), 32'd0);
    check_eq("rst_valid", 32'(bus.valid), 32'd0);
    check_eq("rst_ferr", 32'(bus.ferr), 32'd0);
    check_eq("rst_ovr", 32'(bus.ovr), 32'd0);
    bus.rx = 1'b1;
    tick(5);
    rst_n = 1'b1;
    tick(DIV);
    end_scn("midreset", 0, 0);

    begin_scn();
    rx_exp.push_back(8'h5A);
    echo_exp.push_back(8'h5A);
    send_frame(8'h5A, 1'b1, DIV);
    end_scn("after_reset", 0, 0);

    // Random bytes, random gaps, occasional bad stop bit.
    begin_scn();
    nferr = 0;
    for (int i = 0; i < 12; i++) begin
      b = 8'($urandom);
      if ($urandom_range(0, 4) == 0) begin
        send_frame(b, 1'b0, DIV);
        drive_bit(1'b1, DIV + int'($urandom_range(0, 50)));
        nferr++;
      end else begin
        rx_exp.push_back(b);
        echo_exp.push_back(b);
        send_frame(b, 1'b1, DIV);
        if ($urandom_range(0, 2) != 0) drive_bit(1'b1, int'($urandom_range(1, 300)));
      end
    end
    end_scn("random", nferr, 0);

    $display("");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
